// File: rtl/clmul_pkg.sv
// Shared widths, FSM state type and pass count for the sequential 16x16 carry-less multiplier.
// Defining CLMUL_KARATSUBA_EN selects the 3-pass Karatsuba schedule; otherwise 4 schoolbook passes.
package clmul_pkg;

    localparam int DATA_W   = 16;
    localparam int CORE_W   = 8;
    localparam int PROD_W   = 31;
    localparam int CORE_Y_W = 15;

`ifdef CLMUL_KARATSUBA_EN
    localparam int NPASS = 3;
`else
    localparam int NPASS = 4;
`endif

    localparam int PASS_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/clmul16_seq_core.sv
// Combinational 8x8 carry-less multiply over GF(2), 15-bit unreduced product.
module clmul8_core
    import clmul_pkg::*;
(
    input  logic [CORE_W-1:0]   a,
    input  logic [CORE_W-1:0]   b,
    output logic [CORE_Y_W-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < CORE_W; i++) begin
            if (b[i]) begin
                y = y ^ (CORE_Y_W'(a) << i);
            end
        end
    end

endmodule

// File: rtl/clmul16_seq.sv
// 16x16 carry-less multiplier time-sharing one 8x8 core over NPASS cycles.
// CLMUL_KARATSUBA_EN selects the Karatsuba pass schedule (3 passes) instead of schoolbook (4).
module clmul16_seq
    import clmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_y,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [PASS_W-1:0]   pass_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [PROD_W-1:0]   acc_q;
    logic [CORE_W-1:0]   core_a, core_b;
    logic [CORE_Y_W-1:0] core_y;
    logic [PROD_W-1:0]   y_ext, term;
    logic [CORE_W-1:0]   a_lo, a_hi, b_lo, b_hi;
    logic                accept, last_pass;

    assign a_lo = a_q[CORE_W-1:0];
    assign a_hi = a_q[DATA_W-1:CORE_W];
    assign b_lo = b_q[CORE_W-1:0];
    assign b_hi = b_q[DATA_W-1:CORE_W];

    assign accept    = in_valid && (state_q == S_IDLE);
    assign last_pass = (pass_q == PASS_W'(NPASS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_PASS;
            S_PASS:  if (last_pass) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    // Operand selection and placement of the partial product for the current pass
    always_comb begin
        core_a = '0;
        core_b = '0;
        term   = '0;
`ifdef CLMUL_KARATSUBA_EN
        unique case (pass_q)
            2'd0: begin core_a = a_lo;        core_b = b_lo;        term = y_ext ^ (y_ext << CORE_W); end
            2'd1: begin core_a = a_hi;        core_b = b_hi;        term = (y_ext << CORE_W) ^ (y_ext << (2 * CORE_W)); end
            2'd2: begin core_a = a_lo ^ a_hi; core_b = b_lo ^ b_hi; term = y_ext << CORE_W; end
            default: ;
        endcase
`else
        unique case (pass_q)
            2'd0: begin core_a = a_lo; core_b = b_lo; term = y_ext; end
            2'd1: begin core_a = a_lo; core_b = b_hi; term = y_ext << CORE_W; end
            2'd2: begin core_a = a_hi; core_b = b_lo; term = y_ext << CORE_W; end
            2'd3: begin core_a = a_hi; core_b = b_hi; term = y_ext << (2 * CORE_W); end
            default: ;
        endcase
`endif
    end

    clmul8_core u_core (
        .a (core_a),
        .b (core_b),
        .y (core_y)
    );

    assign y_ext = {{(PROD_W - CORE_Y_W){1'b0}}, core_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            pass_q <= '0;
        end else if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            acc_q  <= '0;
            pass_q <= '0;
        end else if (state_q == S_PASS) begin
            acc_q  <= acc_q ^ term;
            pass_q <= last_pass ? '0 : pass_q + PASS_W'(1);
        end
    end

    assign out_y = acc_q;

endmodule
